// File: rtl/spi_slave_rx_core.sv
// SPI receive-only slave: synchronises the SPI pins into clk, assembles MSB-first
// words and queues them in a first-word-fall-through FIFO with overrun/frame-error reporting.
module spi_slave_rx_core #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned CPOL       = 0,
   parameter int unsigned CPHA       = 0,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          sclk,
   input  logic                          mosi,
   input  logic                          cs_n,
   output logic [DATA_W-1:0]             rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   rx_level,
   output logic                          busy,
   output logic                          frame_err,
   output logic                          overrun,
   input  logic                          overrun_clr
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned CW = $clog2(DATA_W);
   localparam bit SAMPLE_RISE = (CPOL == CPHA);

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [1:0]        sclk_m, cs_m, mosi_m;
   logic              sclk_d, cs_d;
   logic [2:0]        warm;
   logic              cs_fall_c, cs_rise_c, sample_edge_c;
   logic              start_c, end_c, sample_c;
   logic [CW-1:0]     bit_cnt;
   logic [DATA_W-1:0] shift, word_c;
   logic              last_bit_c, word_done_c;
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr, rd_nxt_c;
   logic [LW-1:0]     level_nxt_c;
   logic [DATA_W-1:0] head_nxt_c;
   logic              pop_c, push_c, drop_c, full_c;

   // Pin synchronisers plus history flops; warm masks the reset-valued history so a
   // cs_n held low across reset is never mistaken for a fresh falling edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_m <= {2{1'(CPOL)}};
         cs_m   <= 2'b11;
         mosi_m <= 2'b00;
         sclk_d <= 1'(CPOL);
         cs_d   <= 1'b1;
         warm   <= 3'b000;
      end else begin
         sclk_m <= {sclk_m[0], sclk};
         cs_m   <= {cs_m[0], cs_n};
         mosi_m <= {mosi_m[0], mosi};
         sclk_d <= sclk_m[1];
         cs_d   <= cs_m[1];
         warm   <= {warm[1:0], 1'b1};
      end
   end

   assign cs_fall_c     = warm[2] & cs_d & ~cs_m[1];
   assign cs_rise_c     = ~cs_d & cs_m[1];
   assign sample_edge_c = SAMPLE_RISE ? (sclk_m[1] & ~sclk_d) : (~sclk_m[1] & sclk_d);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cs_fall_c) state_d = ACTIVE;
         ACTIVE:  if (cs_rise_c) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A sample edge coinciding with the frame end is dropped.
   always_comb begin
      start_c  = 1'b0;
      end_c    = 1'b0;
      sample_c = 1'b0;
      case (state_q)
         IDLE:   start_c = cs_fall_c;
         ACTIVE: begin
            end_c    = cs_rise_c;
            sample_c = sample_edge_c & ~cs_rise_c;
         end
         default: ;
      endcase
   end

   assign last_bit_c  = (bit_cnt == CW'(DATA_W - 1));
   assign word_c      = {shift[DATA_W-2:0], mosi_m[1]};
   assign word_done_c = sample_c & last_bit_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt   <= '0;
         shift     <= '0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         frame_err <= end_c && (bit_cnt != '0);
         busy      <= (state_d == ACTIVE);
         if (start_c || end_c || word_done_c) begin
            bit_cnt <= '0;
            shift   <= '0;
         end else if (sample_c) begin
            bit_cnt <= bit_cnt + CW'(1);
            shift   <= word_c;
         end
      end
   end

   // FIFO control: a full FIFO still accepts a word when the head is popped that cycle.
   assign pop_c       = rx_valid & rx_ready;
   assign full_c      = (rx_level == LW'(FIFO_DEPTH));
   assign push_c      = word_done_c & (~full_c | pop_c);
   assign drop_c      = word_done_c & full_c & ~pop_c;
   assign rd_nxt_c    = rd_ptr + AW'(pop_c);
   assign level_nxt_c = rx_level + LW'(push_c) - LW'(pop_c);

   // Next head word, bypassing the array when the new word lands at the head slot.
   always_comb begin
      head_nxt_c = '0;
      if (level_nxt_c != '0) begin
         if (push_c && (wr_ptr == rd_nxt_c)) head_nxt_c = word_c;
         else                                head_nxt_c = mem[rd_nxt_c];
      end
   end

   always_ff @(posedge clk) begin
      if (push_c) mem[wr_ptr] <= word_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         rx_level <= '0;
         rx_valid <= 1'b0;
         rx_data  <= '0;
         overrun  <= 1'b0;
      end else begin
         wr_ptr   <= wr_ptr + AW'(push_c);
         rd_ptr   <= rd_nxt_c;
         rx_level <= level_nxt_c;
         rx_valid <= (level_nxt_c != '0);
         rx_data  <= head_nxt_c;
         overrun  <= drop_c | (overrun & ~overrun_clr);
      end
   end

endmodule

// File: tb/tb_spi_slave_rx_core.sv
// Directed bench for spi_slave_rx_core: mode 0 / 8-bit and mode 3 / 16-bit instances.
`timescale 1ns/1ps
module tb_spi_slave_rx_core;

   logic clk, rst_n;
   logic sclk0, mosi0, cs0, rdy0, clr0;
   logic [7:0] data0;
   logic valid0, busy0, fe0, ovr0;
   logic [2:0] level0;
   logic sclk3, mosi3, cs3, rdy3, clr3;
   logic [15:0] data3;
   logic valid3, busy3, fe3, ovr3;
   logic [2:0] level3;

   int n_checks = 0;
   int n_fail   = 0;
   int fe_cnt0  = 0;
   bit fe_long0 = 0;
   logic fe_prev0 = 0;
   int busy_low3 = 0;
   int fe_base;

   spi_slave_rx_core #(.DATA_W(8), .CPOL(0), .CPHA(0), .FIFO_DEPTH(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .sclk(sclk0), .mosi(mosi0), .cs_n(cs0),
      .rx_data(data0), .rx_valid(valid0), .rx_ready(rdy0), .rx_level(level0),
      .busy(busy0), .frame_err(fe0), .overrun(ovr0), .overrun_clr(clr0));

   spi_slave_rx_core #(.DATA_W(16), .CPOL(1), .CPHA(1), .FIFO_DEPTH(4)) dut3 (
      .clk(clk), .rst_n(rst_n), .sclk(sclk3), .mosi(mosi3), .cs_n(cs3),
      .rx_data(data3), .rx_valid(valid3), .rx_ready(rdy3), .rx_level(level3),
      .busy(busy3), .frame_err(fe3), .overrun(ovr3), .overrun_clr(clr3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (fe0) fe_cnt0++;
      if (fe0 && fe_prev0) fe_long0 = 1;
      fe_prev0 = fe0;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic bit0(input logic b);
      mosi0 = b;
      repeat (4) @(negedge clk);
      sclk0 = 1'b1;
      repeat (4) @(negedge clk);
      sclk0 = 1'b0;
   endtask

   task automatic byte0(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) bit0(v[i]);
   endtask

   task automatic cs_lo0();
      cs0 = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic cs_hi0();
      repeat (4) @(negedge clk);
      cs0 = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic pop0();
      rdy0 = 1'b1;
      @(negedge clk);
      rdy0 = 1'b0;
   endtask

   task automatic bit3(input logic b);
      sclk3 = 1'b0;
      mosi3 = b;
      repeat (4) @(negedge clk);
      sclk3 = 1'b1;
      if (busy3 !== 1'b1) busy_low3++;
      repeat (4) @(negedge clk);
   endtask

   task automatic word3(input logic [15:0] v);
      for (int i = 15; i >= 0; i--) bit3(v[i]);
   endtask

   task automatic pop3();
      rdy3 = 1'b1;
      @(negedge clk);
      rdy3 = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cs0 = 1'b0; sclk0 = 1'b0; mosi0 = 1'b0; rdy0 = 1'b0; clr0 = 1'b0;
      cs3 = 1'b1; sclk3 = 1'b1; mosi3 = 1'b0; rdy3 = 1'b0; clr3 = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({data0, valid0, level0, busy0, fe0, ovr0} !== 15'h0) begin
         n_fail++;
         $display("FAIL reset_m0: got %h required 0", {data0, valid0, level0, busy0, fe0, ovr0});
      end
      n_checks++;
      if ({data3, valid3, level3, busy3, fe3, ovr3} !== 23'h0) begin
         n_fail++;
         $display("FAIL reset_m3: got %h required 0", {data3, valid3, level3, busy3, fe3, ovr3});
      end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      byte0(8'hFF);
      repeat (4) @(negedge clk);
      n_checks++;
      if (level0 !== 3'd0 || busy0 !== 1'b0) begin
         n_fail++;
         $display("FAIL no_frame_after_reset: got level=%0d busy=%b required 0/0", level0, busy0);
      end
      pop0();
      n_checks++;
      if (level0 !== 3'd0 || valid0 !== 1'b0) begin
         n_fail++;
         $display("FAIL pop_empty: got level=%0d valid=%b required 0/0", level0, valid0);
      end
      cs0 = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_single();
      logic [7:0] v;
      v = 8'hA5;
      fe_base = fe_cnt0;
      cs_lo0();
      n_checks++;
      if (busy0 !== 1'b1) begin
         n_fail++;
         $display("FAIL busy_start: got %b required 1", busy0);
      end
      for (int i = 7; i >= 1; i--) bit0(v[i]);
      mosi0 = v[0];
      repeat (4) @(negedge clk);
      sclk0 = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (valid0 !== 1'b0) begin
         n_fail++;
         $display("FAIL latency_early: got valid=%b required 0", valid0);
      end
      @(negedge clk);
      n_checks++;
      if (valid0 !== 1'b1 || data0 !== 8'hA5 || level0 !== 3'd1) begin
         n_fail++;
         $display("FAIL single_word: got valid=%b data=%h level=%0d required 1/a5/1", valid0, data0, level0);
      end
      repeat (1) @(negedge clk);
      sclk0 = 1'b0;
      cs_hi0();
      n_checks++;
      if (fe_cnt0 - fe_base !== 0 || busy0 !== 1'b0) begin
         n_fail++;
         $display("FAIL single_end: got fe_pulses=%0d busy=%b required 0/0", fe_cnt0 - fe_base, busy0);
      end
      pop0();
      n_checks++;
      if (valid0 !== 1'b0 || level0 !== 3'd0) begin
         n_fail++;
         $display("FAIL single_pop: got valid=%b level=%0d required 0/0", valid0, level0);
      end
   endtask

   task automatic test_overrun();
      cs_lo0();
      for (int v = 1; v <= 5; v++) byte0(8'(v));
      cs_hi0();
      n_checks++;
      if (level0 !== 3'd4 || ovr0 !== 1'b1 || data0 !== 8'h01) begin
         n_fail++;
         $display("FAIL overrun_full: got level=%0d ovr=%b data=%h required 4/1/01", level0, ovr0, data0);
      end
      clr0 = 1'b1;
      @(negedge clk);
      clr0 = 1'b0;
      n_checks++;
      if (ovr0 !== 1'b0) begin
         n_fail++;
         $display("FAIL overrun_clr: got %b required 0", ovr0);
      end
      for (int v = 1; v <= 4; v++) begin
         n_checks++;
         if (valid0 !== 1'b1 || data0 !== 8'(v)) begin
            n_fail++;
            $display("FAIL overrun_order: got valid=%b data=%h required 1/%h", valid0, data0, 8'(v));
         end
         pop0();
      end
      n_checks++;
      if (valid0 !== 1'b0 || level0 !== 3'd0) begin
         n_fail++;
         $display("FAIL overrun_drained: got valid=%b level=%0d required 0/0", valid0, level0);
      end
   endtask

   task automatic test_frame_err();
      fe_base = fe_cnt0;
      cs_lo0();
      byte0(8'h3C);
      bit0(1'b1); bit0(1'b0); bit0(1'b1); bit0(1'b1); bit0(1'b0);
      cs_hi0();
      n_checks++;
      if (fe_cnt0 - fe_base !== 1 || fe_long0 !== 1'b0) begin
         n_fail++;
         $display("FAIL frame_err_pulse: got pulses=%0d long=%b required 1/0", fe_cnt0 - fe_base, fe_long0);
      end
      n_checks++;
      if (level0 !== 3'd1 || data0 !== 8'h3C) begin
         n_fail++;
         $display("FAIL frame_err_data: got level=%0d data=%h required 1/3c", level0, data0);
      end
      pop0();
      n_checks++;
      if (level0 !== 3'd0 || valid0 !== 1'b0) begin
         n_fail++;
         $display("FAIL frame_err_partial: got level=%0d valid=%b required 0/0", level0, valid0);
      end
   endtask

   task automatic test_full_pop();
      logic [7:0] v;
      v = 8'h15;
      cs_lo0();
      for (int k = 8'h11; k <= 8'h14; k++) byte0(8'(k));
      for (int i = 7; i >= 1; i--) bit0(v[i]);
      mosi0 = v[0];
      repeat (4) @(negedge clk);
      sclk0 = 1'b1;
      n_checks++;
      if (level0 !== 3'd4) begin
         n_fail++;
         $display("FAIL full_before: got level=%0d required 4", level0);
      end
      repeat (2) @(negedge clk);
      rdy0 = 1'b1;
      @(negedge clk);
      rdy0 = 1'b0;
      n_checks++;
      if (level0 !== 3'd4 || ovr0 !== 1'b0 || data0 !== 8'h12) begin
         n_fail++;
         $display("FAIL full_pop_push: got level=%0d ovr=%b data=%h required 4/0/12", level0, ovr0, data0);
      end
      @(negedge clk);
      sclk0 = 1'b0;
      cs_hi0();
      for (int k = 8'h12; k <= 8'h15; k++) begin
         n_checks++;
         if (valid0 !== 1'b1 || data0 !== 8'(k)) begin
            n_fail++;
            $display("FAIL full_pop_order: got valid=%b data=%h required 1/%h", valid0, data0, 8'(k));
         end
         pop0();
      end
      n_checks++;
      if (level0 !== 3'd0 || ovr0 !== 1'b0) begin
         n_fail++;
         $display("FAIL full_pop_end: got level=%0d ovr=%b required 0/0", level0, ovr0);
      end
   endtask

   task automatic test_mode3();
      busy_low3 = 0;
      cs3 = 1'b0;
      repeat (6) @(negedge clk);
      n_checks++;
      if (busy3 !== 1'b1) begin
         n_fail++;
         $display("FAIL m3_busy_start: got %b required 1", busy3);
      end
      word3(16'h1234);
      word3(16'hBEEF);
      repeat (4) @(negedge clk);
      n_checks++;
      if (busy_low3 !== 0 || busy3 !== 1'b1) begin
         n_fail++;
         $display("FAIL m3_busy_frame: got low_samples=%0d busy=%b required 0/1", busy_low3, busy3);
      end
      cs3 = 1'b1;
      repeat (8) @(negedge clk);
      n_checks++;
      if (busy3 !== 1'b0 || level3 !== 3'd2 || data3 !== 16'h1234) begin
         n_fail++;
         $display("FAIL m3_first: got busy=%b level=%0d data=%h required 0/2/1234", busy3, level3, data3);
      end
      pop3();
      n_checks++;
      if (level3 !== 3'd1 || data3 !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL m3_second: got level=%0d data=%h required 1/beef", level3, data3);
      end
      pop3();
      n_checks++;
      if (level3 !== 3'd0 || valid3 !== 1'b0 || fe3 !== 1'b0) begin
         n_fail++;
         $display("FAIL m3_drained: got level=%0d valid=%b fe=%b required 0/0/0", level3, valid3, fe3);
      end
   endtask

   task automatic test_reset_midframe();
      cs_lo0();
      byte0(8'h77);
      cs_hi0();
      clr0 = 1'b0;
      n_checks++;
      if (level0 !== 3'd1) begin
         n_fail++;
         $display("FAIL midrst_pre: got level=%0d required 1", level0);
      end
      cs_lo0();
      bit0(1'b1); bit0(1'b0); bit0(1'b1); bit0(1'b0);
      #3 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({data0, valid0, level0, busy0, fe0, ovr0} !== 15'h0) begin
         n_fail++;
         $display("FAIL midrst_outputs: got %h required 0", {data0, valid0, level0, busy0, fe0, ovr0});
      end
      cs0 = 1'b1;
      sclk0 = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      fe_base = fe_cnt0;
      cs_lo0();
      byte0(8'h5A);
      cs_hi0();
      n_checks++;
      if (valid0 !== 1'b1 || data0 !== 8'h5A || level0 !== 3'd1 || fe_cnt0 - fe_base !== 0) begin
         n_fail++;
         $display("FAIL midrst_after: got valid=%b data=%h level=%0d fe=%0d required 1/5a/1/0",
                  valid0, data0, level0, fe_cnt0 - fe_base);
      end
      pop0();
   endtask

   initial begin
      test_reset();
      test_single();
      test_overrun();
      test_frame_err();
      test_full_pop();
      test_mode3();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
